// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared branch predictor types, defaults and counter helper
package riscv_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int BTB_ENTRIES_DEF = 64;
  localparam int CTR_BITS_DEF    = 2;
  localparam int RAS_DEPTH_DEF   = 8;

  // Counter storage is sized for the widest supported counter (4 bits).
  localparam int CTR_FIELD_W = 4;
  localparam logic [CTR_FIELD_W-1:0] CTR_ONE = CTR_FIELD_W'(1);

  typedef enum logic [1:0] {
    BT_BRANCH = 2'd0,
    BT_JUMP   = 2'd1,
    BT_CALL   = 2'd2,
    BT_RET    = 2'd3
  } btb_type_e;

  // Tag and target fields are sized for PCs up to XLEN_DEF bits.
  typedef struct packed {
    logic                   valid;
    logic [XLEN_DEF-1:0]    tag;
    btb_type_e              btype;
    logic [XLEN_DEF-1:0]    target;
    logic [CTR_FIELD_W-1:0] ctr;
  } btb_entry_t;

  typedef struct packed {
    logic                          hit;
    logic                          taken;
    logic [XLEN_DEF-1:0]           target;
    logic [$clog2(RAS_DEPTH_DEF):0] ras_ptr;
  } branch_pred_t;

  // Saturating up/down step between 0 and ctr_max.
  function automatic logic [CTR_FIELD_W-1:0] ctr_step(
    input logic [CTR_FIELD_W-1:0] ctr,
    input logic                   inc,
    input logic [CTR_FIELD_W-1:0] ctr_max
  );
    if (inc) return (ctr == ctr_max) ? ctr : ctr + CTR_ONE;
    else     return (ctr == '0)      ? ctr : ctr - CTR_ONE;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// rtl/bpu_ras.sv - circular return address stack with pointer checkpoint restore
module bpu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_data,
  input  logic                     restore,
  input  logic [$clog2(DEPTH):0]   restore_ptr,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   ptr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int W   = $clog2(DEPTH);
  localparam int P_W = W + 1;
  localparam int A_W = W + 3;

  logic [XLEN-1:0]       mem_q [DEPTH];
  logic [XLEN-1:0]       mem_d [DEPTH];
  logic [P_W-1:0]        ptr_q, ptr_d;
  logic [P_W-1:0]        count_q, count_d;
  logic [P_W-1:0]        diff;
  logic signed [A_W-1:0] cnt_adj;
  logic [W-1:0]          top_idx;

  // The pointer carries one wrap bit beyond the slot index so a snapshot
  // also tells how far the stack moved since it was taken.
  assign top_idx = ptr_q[W-1:0] - W'(1);
  assign top     = mem_q[top_idx];
  assign ptr     = ptr_q;
  assign count   = count_q;

  // Next-state: restore wins; otherwise push (overwriting oldest when full) or pop.
  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    diff    = ptr_q - restore_ptr;
    cnt_adj = $signed({2'b00, count_q}) - $signed({{2{diff[P_W-1]}}, diff});
    if (restore) begin
      ptr_d = restore_ptr;
      // Undo the net speculative pushes/pops, clamped to a legal occupancy.
      if (cnt_adj[A_W-1])                      count_d = '0;
      else if (cnt_adj > $signed(A_W'(DEPTH))) count_d = P_W'(DEPTH);
      else                                     count_d = cnt_adj[P_W-1:0];
    end else if (push) begin
      mem_d[ptr_q[W-1:0]] = push_data;
      ptr_d               = ptr_q + P_W'(1);
      if (count_q != P_W'(DEPTH)) count_d = count_q + P_W'(1);
    end else if (pop) begin
      ptr_d   = ptr_q - P_W'(1);
      count_d = count_q - P_W'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// rtl/branch_pred_unit.sv - direct-mapped BTB with saturating counters plus RAS
module branch_pred_unit
  import riscv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
  parameter int CTR_BITS    = CTR_BITS_DEF,
  parameter int RAS_DEPTH   = RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lookup_valid,
  input  logic [XLEN-1:0]              lookup_pc,
  output logic                         pred_hit,
  output logic                         pred_taken,
  output logic [XLEN-1:0]              pred_target,
  output logic [$clog2(RAS_DEPTH):0]   pred_ras_ptr,
  input  logic                         upd_valid,
  input  logic [XLEN-1:0]              upd_pc,
  input  btb_type_e                    upd_type,
  input  logic                         upd_taken,
  input  logic [XLEN-1:0]              upd_target,
  input  logic                         upd_mispredict,
  input  logic [$clog2(RAS_DEPTH):0]   upd_ras_ptr
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int P_W   = $clog2(RAS_DEPTH) + 1;
  localparam logic [CTR_FIELD_W-1:0] CTR_MAX = CTR_FIELD_W'((1 << CTR_BITS) - 1);
  localparam logic [CTR_FIELD_W-1:0] CTR_WNT = CTR_FIELD_W'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_FIELD_W-1:0] CTR_WT  = CTR_FIELD_W'(1 << (CTR_BITS - 1));

  btb_entry_t btb_q [BTB_ENTRIES];
  btb_entry_t btb_d [BTB_ENTRIES];

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [XLEN_DEF-1:0] lk_tag, up_tag;
  btb_entry_t          lk_e, up_e;
  logic                lk_hit, up_hit;
  logic [XLEN-1:0]     pc_plus4;
  logic                ras_push, ras_pop;
  logic [XLEN-1:0]     ras_top;
  logic [P_W-1:0]      ras_ptr, ras_count;
  logic                unused_upd_pc_lsb;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = XLEN_DEF'(lookup_pc[XLEN-1:IDX_W+2]);
  assign lk_e     = btb_q[lk_idx];
  assign lk_hit   = lookup_valid && lk_e.valid && (lk_e.tag == lk_tag);
  assign pc_plus4 = lookup_pc + XLEN'(4);

  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = XLEN_DEF'(upd_pc[XLEN-1:IDX_W+2]);
  assign up_e     = btb_q[up_idx];
  assign up_hit   = up_e.valid && (up_e.tag == up_tag);

  assign unused_upd_pc_lsb = ^upd_pc[1:0];
  assign pred_ras_ptr      = ras_ptr;

  // Same-cycle prediction from the registered tables; also decides RAS push/pop.
  always_comb begin
    pred_hit    = lk_hit;
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    if (lk_hit) begin
      case (lk_e.btype)
        BT_BRANCH: begin
          pred_taken = lk_e.ctr[CTR_BITS-1];
          if (lk_e.ctr[CTR_BITS-1]) pred_target = lk_e.target[XLEN-1:0];
        end
        BT_JUMP: begin
          pred_taken  = 1'b1;
          pred_target = lk_e.target[XLEN-1:0];
        end
        BT_CALL: begin
          pred_taken  = 1'b1;
          pred_target = lk_e.target[XLEN-1:0];
          ras_push    = 1'b1;
        end
        BT_RET: begin
          // An empty stack has nothing to return to; fall through sequentially.
          if (ras_count != '0) begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
            ras_pop     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Training from resolved outcomes: counter step on hit, allocate on useful miss.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid) begin
      if (up_hit) begin
        if (upd_type == BT_BRANCH) btb_d[up_idx].ctr = ctr_step(up_e.ctr, upd_taken, CTR_MAX);
        else                       btb_d[up_idx].ctr = CTR_MAX;
        if (upd_taken) begin
          btb_d[up_idx].btype  = upd_type;
          btb_d[up_idx].target = XLEN_DEF'(upd_target);
        end
      end else if (upd_taken || (upd_type != BT_BRANCH)) begin
        btb_d[up_idx].valid  = 1'b1;
        btb_d[up_idx].tag    = up_tag;
        btb_d[up_idx].btype  = upd_type;
        btb_d[up_idx].target = XLEN_DEF'(upd_target);
        if (upd_type != BT_BRANCH) btb_d[up_idx].ctr = CTR_MAX;
        else if (upd_taken)        btb_d[up_idx].ctr = CTR_WT;
        else                       btb_d[up_idx].ctr = CTR_WNT;
      end
    end
  end

  // BTB registers: invalid and weakly-not-taken out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, btype: BT_BRANCH, target: '0, ctr: CTR_WNT};
      end
    end else begin
      btb_q <= btb_d;
    end
  end

  bpu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_data   (pc_plus4),
    .restore     (upd_valid && upd_mispredict),
    .restore_ptr (upd_ras_ptr),
    .top         (ras_top),
    .ptr         (ras_ptr),
    .count       (ras_count)
  );

endmodule

// File: tb/tb_branch_pred_unit.sv
// tb/tb_branch_pred_unit.sv - self-checking bench for branch_pred_unit
module tb_branch_pred_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [3:0]  pred_ras_ptr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  btb_type_e   upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [3:0]  upd_ras_ptr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        chk_ptr;
    logic [3:0]  ptr;
  } exp_t;

  typedef struct packed {
    logic        upd_taken;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  exp_t  exp_q [$];
  string name_q [$];
  vec_t  vecs [11];

  branch_pred_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_ras_ptr   (pred_ras_ptr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_type       (upd_type),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .upd_ras_ptr    (upd_ras_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic lk(input logic v, input logic [31:0] pc, input logic h, input logic t,
                    input logic [31:0] tg, input logic cp, input logic [3:0] p, input string nm);
    exp_t e;
    lookup_valid = v;
    lookup_pc    = pc;
    e = '{hit: h, taken: t, target: tg, chk_ptr: cp, ptr: p};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic upd(input logic [31:0] pc, input btb_type_e ty, input logic tk,
                     input logic [31:0] tg, input logic mis, input logic [3:0] rp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_type       = ty;
    upd_taken      = tk;
    upd_target     = tg;
    upd_mispredict = mis;
    upd_ras_ptr    = rp;
  endtask

  task automatic step();
    exp_t  e;
    string nm;
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.target}) begin
        bad++;
        $display("FAIL %s: got hit=%0d taken=%0d target=0x%h, need hit=%0d taken=%0d target=0x%h",
                 nm, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
      end
      if (e.chk_ptr) begin
        total++;
        if (pred_ras_ptr !== e.ptr) begin
          bad++;
          $display("FAIL %s_ptr: got ras_ptr=%0d, need %0d", nm, pred_ras_ptr, e.ptr);
        end
      end
    end
    @(posedge clk);
    #1;
    lookup_valid   = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    logic        ph, pt;
    logic [31:0] ptg;

    vecs[0]  = '{1'b1, 1'b1, 32'h80};
    vecs[1]  = '{1'b0, 1'b0, 32'h204};
    vecs[2]  = '{1'b1, 1'b1, 32'h80};
    vecs[3]  = '{1'b1, 1'b1, 32'h80};
    vecs[4]  = '{1'b1, 1'b1, 32'h80};
    vecs[5]  = '{1'b0, 1'b1, 32'h80};
    vecs[6]  = '{1'b0, 1'b0, 32'h204};
    vecs[7]  = '{1'b0, 1'b0, 32'h204};
    vecs[8]  = '{1'b0, 1'b0, 32'h204};
    vecs[9]  = '{1'b1, 1'b0, 32'h204};
    vecs[10] = '{1'b1, 1'b1, 32'h80};

    rst_n          = 1'b1;
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_type       = BT_BRANCH;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    upd_ras_ptr    = '0;
    #1 rst_n = 1'b0;

    lk(1, 32'h100, 0, 0, 32'h104, 1, 0, "in_reset");
    step();
    rst_n = 1'b1;
    lk(1, 32'h100, 0, 0, 32'h104, 1, 0, "after_reset");
    step();

    // Counter training table; each update cycle also checks the lookup sees old contents.
    ph = 1'b0; pt = 1'b0; ptg = 32'h204;
    for (int i = 0; i < 11; i++) begin
      upd(32'h200, BT_BRANCH, vecs[i].upd_taken, 32'h80, 1'b0, 4'd0);
      lk(1, 32'h200, ph, pt, ptg, 0, 0, "same_cycle_old");
      step();
      lk(1, 32'h200, 1, vecs[i].exp_taken, vecs[i].exp_target, 0, 0, "ctr_table");
      step();
      ph = 1'b1; pt = vecs[i].exp_taken; ptg = vecs[i].exp_target;
    end

    // Call then matching return.
    upd(32'h300, BT_CALL, 1, 32'h400, 1'b0, 4'd0); step();
    upd(32'h404, BT_RET,  1, 32'h123, 1'b0, 4'd0); step();
    lk(1, 32'h300, 1, 1, 32'h400, 1, 0, "call"); step();
    lk(1, 32'h404, 1, 1, 32'h304, 1, 1, "ret"); step();
    lk(1, 32'h404, 1, 0, 32'h408, 1, 0, "ret_empty"); step();

    // Nine calls overflow an 8-deep stack; nine returns.
    for (int k = 0; k < 9; k++) begin
      upd(32'h5000 + 32'(8 * k), BT_CALL, 1, 32'h7000, 1'b0, 4'd0);
      step();
    end
    for (int k = 0; k < 9; k++) begin
      lk(1, 32'h5000 + 32'(8 * k), 1, 1, 32'h7000, 1, 4'(k), "call9");
      step();
    end
    for (int j = 0; j < 8; j++) begin
      lk(1, 32'h404, 1, 1, 32'h5004 + 32'(8 * (8 - j)), 1, 4'(9 - j), "ret9");
      step();
    end
    lk(1, 32'h404, 1, 0, 32'h408, 1, 1, "ret9_empty"); step();

    // Reset dropped mid-cycle must clear state before the next clock edge.
    rst_n = 1'b0;
    lk(1, 32'h5040, 0, 0, 32'h5044, 1, 0, "async_reset");
    step();
    rst_n = 1'b1;

    // Checkpoint restore beats a same-cycle call push.
    upd(32'h5000, BT_CALL, 1, 32'h6000, 1'b0, 4'd0); step();
    upd(32'h404,  BT_RET,  1, 32'h123,  1'b0, 4'd0); step();
    for (int k = 0; k < 5; k++) begin
      lk(1, 32'h5000, 1, 1, 32'h6000, 1, 4'(k), "spec_call");
      step();
    end
    lk(1, 32'h5000, 1, 1, 32'h6000, 1, 5, "restore_cycle");
    upd(32'h5000, BT_CALL, 1, 32'h6000, 1'b1, 4'd2);
    step();
    lk(1, 32'h404,  1, 1, 32'h5004, 1, 2, "after_restore"); step();
    lk(1, 32'h5000, 1, 1, 32'h6000, 1, 1, "after_pop"); step();

    // Not-taken branch miss does not allocate.
    upd(32'h700, BT_BRANCH, 0, 32'h900, 1'b0, 4'd0); step();
    lk(1, 32'h700, 0, 0, 32'h704, 1, 2, "nt_no_alloc"); step();

    // Aliasing index: second allocation evicts the first.
    upd(32'h1000, BT_JUMP, 1, 32'hA00, 1'b0, 4'd0); step();
    lk(1, 32'h1000, 1, 1, 32'hA00, 0, 0, "jump"); step();
    upd(32'h1100, BT_JUMP, 1, 32'hB00, 1'b0, 4'd0); step();
    lk(1, 32'h1000, 0, 0, 32'h1004, 0, 0, "evicted"); step();
    lk(1, 32'h1100, 1, 1, 32'hB00, 0, 0, "evictor"); step();
    lk(0, 32'h1100, 0, 0, 32'h1104, 0, 0, "valid_low"); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
